stage_if: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Holds the PC register and a direct-mapped branch target buffer (BTB), and drives the combinational instruction-memory read address.
- Owns the IF/ID pipeline register that delivers pc/instr/pred_taken to decode.
- Consumes decode's redirect and BTB-update outputs, plus stall/flush from the hazard unit.

---
 rtl/if_pkg.sv | 26 ++
 rtl/if_btb.sv | 55 +++++
 rtl/stage_if.sv | 92 +++++++++
 tb/tb_stage_if.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: reset defaults, the NOP
// encoding and the BTB entry layout.
package if_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned BTB_ENTRIES_DEF = 16;
    localparam int unsigned BTB_MIN_ENTRIES = 2;

    // Tag covers everything above the index and the two byte-offset bits.
    function automatic int unsigned btb_tag_w(input int unsigned entries);
        return 32 - 2 - $clog2(entries);
    endfunction

    // Sized for the smallest legal BTB, so any depth's tag fits zero-extended.
    localparam int unsigned BTB_TAG_W = btb_tag_w(BTB_MIN_ENTRIES);

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;

endpackage

// File: rtl/if_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous write,
// valid bits cleared only by reset. Writes are not bypassed to the lookup port.
module if_btb
    import if_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lookup_pc,
    output logic        o_hit,
    output logic [31:0] o_target,
    input  logic        i_update,
    input  logic [31:0] i_update_pc,
    input  logic [31:0] i_update_target
);

    localparam int unsigned IDX = $clog2(BTB_ENTRIES);

    btb_entry_t r_mem [BTB_ENTRIES];

    logic [IDX-1:0]       w_rd_idx;
    logic [IDX-1:0]       w_wr_idx;
    logic [BTB_TAG_W-1:0] w_rd_tag;
    logic [BTB_TAG_W-1:0] w_wr_tag;
    btb_entry_t           w_rd_entry;
    logic                 w_unused_offset;

    assign w_rd_idx = i_lookup_pc[IDX+1:2];
    assign w_wr_idx = i_update_pc[IDX+1:2];
    assign w_rd_tag = BTB_TAG_W'(i_lookup_pc[31:IDX+2]);
    assign w_wr_tag = BTB_TAG_W'(i_update_pc[31:IDX+2]);

    // Byte-offset bits never participate in index or tag.
    assign w_unused_offset = ^{i_lookup_pc[1:0], i_update_pc[1:0]};

    // Lookup against the current PC, same cycle.
    always_comb begin
        w_rd_entry = r_mem[w_rd_idx];
        o_hit      = w_rd_entry.valid && (w_rd_entry.tag == w_rd_tag);
        o_target   = w_rd_entry.target;
    end

    // Reset clears only valid bits; otherwise an update overwrites its slot.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else if (i_update) begin
            r_mem[w_wr_idx] <= '{valid: 1'b1, tag: w_wr_tag, target: i_update_target};
        end
    end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC register, optional BTB and the IF/ID register.
// Build option: define STAGE_IF_BTB_EN to include the BTB; without it the
// stage never predicts taken and ignores BTB update inputs.
module stage_if
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_btb_update,
    input  logic [31:0] i_btb_update_pc,
    input  logic [31:0] i_btb_update_target,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_pred_taken,
    output logic        o_valid
);

    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic        w_hit;
    logic [31:0] w_btb_target;

`ifdef STAGE_IF_BTB_EN
    if_btb #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_lookup_pc     (r_pc),
        .o_hit           (w_hit),
        .o_target        (w_btb_target),
        .i_update        (i_btb_update),
        .i_update_pc     (i_btb_update_pc),
        .i_update_target (i_btb_update_target)
    );
`else
    logic w_unused_btb;

    assign w_hit        = 1'b0;
    assign w_btb_target = 32'h0;
    assign w_unused_btb = ^{i_btb_update, i_btb_update_pc, i_btb_update_target,
                            32'(BTB_ENTRIES)};
`endif

    assign o_imem_addr = r_pc;

    // Next PC: redirect beats stall, stall beats prediction, else sequential.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (i_redirect_valid) begin
            w_next_pc = i_redirect_pc;
        end else if (i_stall) begin
            w_next_pc = r_pc;
        end else if (w_hit) begin
            w_next_pc = w_btb_target;
        end
    end

    // PC register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // IF/ID register: flush inserts a bubble, stall holds, otherwise capture.
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_flush) begin
            o_pc         <= 32'h0;
            o_instr      <= NOP_INSTR;
            o_pred_taken <= 1'b0;
            o_valid      <= 1'b0;
        end else if (!i_stall) begin
            o_pc         <= r_pc;
            o_instr      <= i_imem_rdata;
            o_pred_taken <= w_hit;
            o_valid      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed scenarios followed by random traffic, all
// checked against a behavioural model of the fetch stage and its BTB.
module tb_stage_if;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam int unsigned ENTRIES = 16;
`ifdef STAGE_IF_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, rv, bu;
    logic [31:0] rpc, bpc, btgt;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_pc, if_instr;
    logic        if_pred, if_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state.
    logic [31:0] m_pc, m_if_pc, m_if_instr;
    logic        m_if_pred, m_if_valid;
    logic        m_bv   [ENTRIES];
    logic [31:0] m_bpc  [ENTRIES];
    logic [31:0] m_btgt [ENTRIES];

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h00A0_0093 : (a ^ 32'h1357_9BDF);
    endfunction

    assign imem_rdata = imem(imem_addr);

    stage_if dut (
        .i_clk               (clk),
        .i_reset             (rst_n),
        .i_stall             (stall),
        .i_flush             (flush),
        .i_redirect_valid    (rv),
        .i_redirect_pc       (rpc),
        .i_btb_update        (bu),
        .i_btb_update_pc     (bpc),
        .i_btb_update_target (btgt),
        .o_imem_addr         (imem_addr),
        .i_imem_rdata        (imem_rdata),
        .o_pc                (if_pc),
        .o_instr             (if_instr),
        .o_pred_taken        (if_pred),
        .o_valid             (if_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Entry slot is word address modulo depth; match compares all higher bits.
    function automatic logic model_hit(input logic [31:0] pc);
        int unsigned s = (pc / 4) % ENTRIES;
        return BTB_ON && m_bv[s] && ((m_bpc[s] / (4 * ENTRIES)) == (pc / (4 * ENTRIES)));
    endfunction

    task automatic step(input logic r_n, input logic st, input logic fl, input logic rd,
                        input logic [31:0] rp, input logic up, input logic [31:0] up_pc,
                        input logic [31:0] up_tgt);
        logic        h;
        logic [31:0] t;
        rst_n = r_n; stall = st; flush = fl; rv = rd; rpc = rp;
        bu = up; bpc = up_pc; btgt = up_tgt;
        h = model_hit(m_pc);
        t = m_btgt[(m_pc / 4) % ENTRIES];
        if (!r_n) begin
            m_pc = RST_PC;
            m_if_pc = 32'h0; m_if_instr = 32'h13; m_if_pred = 1'b0; m_if_valid = 1'b0;
            for (int i = 0; i < int'(ENTRIES); i++) m_bv[i] = 1'b0;
        end else begin
            if (fl) begin
                m_if_pc = 32'h0; m_if_instr = 32'h13; m_if_pred = 1'b0; m_if_valid = 1'b0;
            end else if (!st) begin
                m_if_pc = m_pc; m_if_instr = imem(m_pc); m_if_pred = h; m_if_valid = 1'b1;
            end
            if (up) begin
                m_bv[(up_pc / 4) % ENTRIES]   = 1'b1;
                m_bpc[(up_pc / 4) % ENTRIES]  = up_pc;
                m_btgt[(up_pc / 4) % ENTRIES] = up_tgt;
            end
            m_pc = rd ? rp : st ? m_pc : h ? t : m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("if_pc", if_pc, m_if_pc);
        chk("if_instr", if_instr, m_if_instr);
        chk("if_pred", {31'b0, if_pred}, {31'b0, m_if_pred});
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_if_valid});
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic redirect(input logic [31:0] to, input logic fl);
        step(1'b1, 1'b0, fl, 1'b1, to, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic learn(input logic [31:0] pc, input logic [31:0] tgt);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, pc, tgt);
    endtask

    initial begin
        m_pc = 32'h0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_bv[i] = 1'b0; m_bpc[i] = 32'h0; m_btgt[i] = 32'h0;
        end

        // Reset and first fetches.
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h0, 32'h8);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", if_instr, 32'h0000_0013);
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        idle();
        chk("first_addr", imem_addr, 32'h4);
        chk("first_pc", if_pc, 32'h0);
        chk("first_instr", if_instr, 32'h00A0_0093);
        chk("first_valid", {31'b0, if_valid}, 32'h1);
        chk("first_pred", {31'b0, if_pred}, 32'h0);
        idle();
        chk("second_addr", imem_addr, 32'h8);

        // BTB learn then hit at 0x10.
        learn(32'h10, 32'h40);
        idle();
        chk("pre_hit_addr", imem_addr, 32'h10);
        idle();
        chk("hit_addr", imem_addr, BTB_ON ? 32'h40 : 32'h14);
        chk("hit_pred", {31'b0, if_pred}, {31'b0, BTB_ON});
        chk("hit_pc", if_pc, 32'h10);

        // Stall with pc=0x20 for three cycles.
        redirect(32'h1C, 1'b1);
        idle();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
            chk("stall_addr", imem_addr, 32'h20);
            chk("stall_pc", if_pc, 32'h1C);
            chk("stall_instr", if_instr, imem(32'h1C));
        end
        idle();
        chk("unstall_addr", imem_addr, 32'h24);
        chk("unstall_pc", if_pc, 32'h20);

        // Redirect + flush + stall together.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0);
        chk("rfs_addr", imem_addr, 32'h80);
        chk("rfs_instr", if_instr, 32'h0000_0013);
        chk("rfs_valid", {31'b0, if_valid}, 32'h0);

        // Aliasing: 0x50 evicts 0x10 from the shared slot.
        learn(32'h10, 32'h40);
        learn(32'h50, 32'h60);
        redirect(32'h10, 1'b1);
        idle();
        chk("alias_pred", {31'b0, if_pred}, 32'h0);
        chk("alias_addr", imem_addr, 32'h14);

        // 32-bit wrap of the sequential PC.
        redirect(32'hFFFF_FFFC, 1'b1);
        idle();
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset mid-run clears learned entries.
        learn(32'h10, 32'h40);
        redirect(32'h40, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("mid_rst_addr", imem_addr, RST_PC);
        chk("mid_rst_valid", {31'b0, if_valid}, 32'h0);
        redirect(32'h10, 1'b0);
        idle();
        chk("mid_rst_pred", {31'b0, if_pred}, 32'h0);
        chk("mid_rst_next", imem_addr, 32'h14);

        // Random traffic in a small address window so the BTB sees hits.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                 ($urandom_range(0, 2) == 0),
                 {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                 {24'h0, 6'($urandom_range(0, 63)), 2'b00});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
